// File: rtl/atm_keypad_entry_if.sv
// Keypad/card levels toward the entry block and the controller-facing strobes back out.
// master = keypad/system side, slave = atm_keypad_entry.
interface atm_keypad_entry_if;
    logic        tarjeta_recibida;
    logic        amount_en;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  digito;
    logic        add_digit;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic [3:0]  digit_count;
    logic        key_err;

    modport master (
        output tarjeta_recibida, amount_en, key_valid, key_code,
        input  digito, add_digit, digito_stb, monto, monto_stb, digit_count, key_err
    );

    modport slave (
        input  tarjeta_recibida, amount_en, key_valid, key_code,
        output digito, add_digit, digito_stb, monto, monto_stb, digit_count, key_err
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// Keypad front end: PIN digit strobes and decimal-to-binary amount entry for the ATM FSM.
// Latency 1 cycle, all outputs registered; no backpressure, one key per key_valid pulse.
module atm_keypad_entry #(
    parameter int PIN_LEN        = 4,
    parameter int AMT_MAX_DIGITS = 9
) (
    input  logic               clk,
    input  logic               rst,
    atm_keypad_entry_if.slave  kp
);
    typedef enum logic [1:0] {S_IDLE, S_PIN, S_AMOUNT, S_HOLD} state_t;

    localparam logic [3:0] PIN_LEN_C = 4'(PIN_LEN);
    localparam logic [3:0] AMT_MAX_C = 4'(AMT_MAX_DIGITS);
    localparam logic [3:0] K_ENTER   = 4'hA;
    localparam logic [3:0] K_CLEAR   = 4'hB;
    localparam logic [3:0] K_CANCEL  = 4'hC;

    state_t      state_q, state_d;
    logic [3:0]  pin_cnt_q, pin_cnt_d;
    logic [3:0]  amt_cnt_q, amt_cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] monto_q, monto_d;
    logic [3:0]  digito_q, digito_d;
    logic        add_digit_q, add_digit_d;
    logic        digito_stb_q, digito_stb_d;
    logic        monto_stb_q, monto_stb_d;
    logic        key_err_q, key_err_d;
    logic [3:0]  digit_count_q, digit_count_d;

    logic        is_digit;
    logic [31:0] acc_next;

    assign is_digit = (kp.key_code <= 4'd9);
    assign acc_next = (acc_q * 32'd10) + {28'd0, kp.key_code};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pin_cnt_q     <= '0;
            amt_cnt_q     <= '0;
            acc_q         <= '0;
            monto_q       <= '0;
            digito_q      <= '0;
            add_digit_q   <= 1'b0;
            digito_stb_q  <= 1'b0;
            monto_stb_q   <= 1'b0;
            key_err_q     <= 1'b0;
            digit_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pin_cnt_q     <= pin_cnt_d;
            amt_cnt_q     <= amt_cnt_d;
            acc_q         <= acc_d;
            monto_q       <= monto_d;
            digito_q      <= digito_d;
            add_digit_q   <= add_digit_d;
            digito_stb_q  <= digito_stb_d;
            monto_stb_q   <= monto_stb_d;
            key_err_q     <= key_err_d;
            digit_count_q <= digit_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pin_cnt_d    = pin_cnt_q;
        amt_cnt_d    = amt_cnt_q;
        acc_d        = acc_q;
        monto_d      = monto_q;
        digito_d     = digito_q;
        add_digit_d  = 1'b0;
        digito_stb_d = 1'b0;
        monto_stb_d  = 1'b0;
        key_err_d    = 1'b0;

        // Card removal and CANCEL both abandon the session; the key itself is dropped.
        if ((state_q != S_IDLE) &&
            (!kp.tarjeta_recibida || (kp.key_valid && kp.key_code == K_CANCEL))) begin
            state_d   = S_IDLE;
            pin_cnt_d = '0;
            amt_cnt_d = '0;
            acc_d     = '0;
            monto_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (kp.tarjeta_recibida) begin
                        state_d   = S_PIN;
                        pin_cnt_d = '0;
                    end
                end
                S_PIN: begin
                    if (kp.amount_en) begin
                        state_d   = S_AMOUNT;
                        acc_d     = '0;
                        amt_cnt_d = '0;
                    end else if (kp.key_valid) begin
                        if (is_digit) begin
                            if (pin_cnt_q < PIN_LEN_C) begin
                                digito_d    = kp.key_code;
                                add_digit_d = 1'b1;
                                pin_cnt_d   = pin_cnt_q + 4'd1;
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end else if (kp.key_code == K_ENTER) begin
                            if (pin_cnt_q == PIN_LEN_C) begin
                                digito_stb_d = 1'b1;
                                pin_cnt_d    = '0;
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end else if (kp.key_code == K_CLEAR) begin
                            pin_cnt_d = '0;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                end
                S_AMOUNT: begin
                    if (!kp.amount_en) begin
                        state_d   = S_PIN;
                        pin_cnt_d = '0;
                        acc_d     = '0;
                        amt_cnt_d = '0;
                    end else if (kp.key_valid) begin
                        if (is_digit) begin
                            if (amt_cnt_q < AMT_MAX_C) begin
                                acc_d     = acc_next;
                                amt_cnt_d = amt_cnt_q + 4'd1;
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end else if (kp.key_code == K_ENTER) begin
                            if (amt_cnt_q != 4'd0) begin
                                monto_d     = acc_q;
                                monto_stb_d = 1'b1;
                                state_d     = S_HOLD;
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end else if (kp.key_code == K_CLEAR) begin
                            acc_d     = '0;
                            amt_cnt_d = '0;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // Amount is frozen here; only CLEAR reopens entry.
                    if (kp.key_valid) begin
                        if (kp.key_code == K_CLEAR) begin
                            state_d   = S_AMOUNT;
                            acc_d     = '0;
                            amt_cnt_d = '0;
                            monto_d   = '0;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_PIN:            digit_count_d = pin_cnt_d;
            S_AMOUNT, S_HOLD: digit_count_d = amt_cnt_d;
            default:          digit_count_d = '0;
        endcase
    end

    always_comb begin
        kp.digito      = digito_q;
        kp.add_digit   = add_digit_q;
        kp.digito_stb  = digito_stb_q;
        kp.monto       = monto_q;
        kp.monto_stb   = monto_stb_q;
        kp.digit_count = digit_count_q;
        kp.key_err     = key_err_q;
    end
endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboarded bench for atm_keypad_entry: directed scenarios then random keys against a digit-list model.
module tb_atm_keypad_entry;
    localparam int PIN_LEN = 4;
    localparam int AMT_MAX = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atm_keypad_entry_if kif();

    atm_keypad_entry #(.PIN_LEN(PIN_LEN), .AMT_MAX_DIGITS(AMT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.slave)
    );

    typedef struct {
        int     cycle;
        bit     add;
        bit     stb;
        bit     mstb;
        bit     err;
        int     digito;
        longint monto;
        int     dcnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   cur_tj = 1'b0;
    bit   cur_am = 1'b0;

    // Reference session: 0 idle, 1 PIN, 2 amount entry, 3 amount held
    int   mode = 0;
    int   pin_n = 0;
    int   amt_digits[$];
    longint m_monto = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint digits_value();
        longint v = 0;
        foreach (amt_digits[i]) v = v * 10 + amt_digits[i];
        return v;
    endfunction

    task automatic model_drop();
        mode = 0;
        pin_n = 0;
        amt_digits.delete();
        m_monto = 0;
    endtask

    task automatic model(input bit tj, input bit am, input bit kv, input logic [3:0] kc);
        exp_t e;
        e = '{cycle: cyc + 1, add: 0, stb: 0, mstb: 0, err: 0, digito: 0, monto: 0, dcnt: 0};
        if (mode != 0 && (!tj || (kv && kc == 4'hC))) begin
            model_drop();
        end else if (mode == 0) begin
            if (tj) begin mode = 1; pin_n = 0; end
        end else if (mode == 1) begin
            if (am) begin
                mode = 2; amt_digits.delete();
            end else if (kv) begin
                if (kc <= 9) begin
                    if (pin_n < PIN_LEN) begin e.add = 1; e.digito = int'(kc); pin_n++; end
                    else e.err = 1;
                end else if (kc == 4'hA) begin
                    if (pin_n == PIN_LEN) begin e.stb = 1; pin_n = 0; end
                    else e.err = 1;
                end else if (kc == 4'hB) pin_n = 0;
                else e.err = 1;
            end
        end else if (mode == 2) begin
            if (!am) begin
                mode = 1; pin_n = 0; amt_digits.delete();
            end else if (kv) begin
                if (kc <= 9) begin
                    if (amt_digits.size() < AMT_MAX) amt_digits.push_back(int'(kc));
                    else e.err = 1;
                end else if (kc == 4'hA) begin
                    if (amt_digits.size() > 0) begin m_monto = digits_value(); e.mstb = 1; mode = 3; end
                    else e.err = 1;
                end else if (kc == 4'hB) amt_digits.delete();
                else e.err = 1;
            end
        end else begin
            if (kv) begin
                if (kc == 4'hB) begin mode = 2; amt_digits.delete(); m_monto = 0; end
                else e.err = 1;
            end
        end
        e.monto = m_monto;
        e.dcnt  = (mode == 1) ? pin_n : ((mode >= 2) ? amt_digits.size() : 0);
        if (e.add || e.stb || e.mstb || e.err) sb.push_back(e);
    endtask

    task automatic step(input bit tj, input bit am, input bit kv, input logic [3:0] kc);
        @(negedge clk);
        kif.tarjeta_recibida = tj;
        kif.amount_en        = am;
        kif.key_valid        = kv;
        kif.key_code         = kc;
        model(tj, am, kv, kc);
    endtask

    task automatic key(input logic [3:0] kc);
        step(cur_tj, cur_am, 1'b1, kc);
    endtask

    task automatic idle();
        step(cur_tj, cur_am, 1'b0, 4'h0);
    endtask

    // Monitor: pops an expectation whenever the DUT shows any strobe
    always @(negedge clk) begin
        if (rst) begin
            while (sb.size() > 0 && sb[0].cycle < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: no strobe seen, expected one at cycle %0d (now %0d)", sb[0].cycle, cyc);
                void'(sb.pop_front());
            end
            if (kif.add_digit || kif.digito_stb || kif.monto_stb || kif.key_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: add=%0b stb=%0b mstb=%0b err=%0b, expected none (cycle %0d)",
                             kif.add_digit, kif.digito_stb, kif.monto_stb, kif.key_err, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_cycle", cyc, e.cycle);
                    chk("add_digit", kif.add_digit, e.add);
                    chk("digito_stb", kif.digito_stb, e.stb);
                    chk("monto_stb", kif.monto_stb, e.mstb);
                    chk("key_err", kif.key_err, e.err);
                    if (e.add) chk("digito", kif.digito, e.digito);
                    chk("monto", kif.monto, e.monto);
                    chk("digit_count", kif.digit_count, e.dcnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        kif.tarjeta_recibida = 1'b0;
        kif.amount_en        = 1'b0;
        kif.key_valid        = 1'b0;
        kif.key_code         = 4'h0;
        #12;
        chk("rst_digito", kif.digito, 0);
        chk("rst_add_digit", kif.add_digit, 0);
        chk("rst_digito_stb", kif.digito_stb, 0);
        chk("rst_monto", kif.monto, 0);
        chk("rst_monto_stb", kif.monto_stb, 0);
        chk("rst_digit_count", kif.digit_count, 0);
        chk("rst_key_err", kif.key_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // PIN 4756 then ENTER
        cur_tj = 1'b1;
        idle();
        key(4'd4); key(4'd7); key(4'd5); key(4'd6); key(4'hA);
        idle();

        // Short PIN ENTER, then overfill
        key(4'd1); key(4'd2); key(4'hA);
        key(4'd3); key(4'd4); key(4'd5); key(4'd6); key(4'd9);
        idle();

        // Amount 04500
        cur_am = 1'b1;
        idle();
        key(4'd0); key(4'd4); key(4'd5); key(4'd0); key(4'd0); key(4'hA);
        idle();
        chk("monto_4500", kif.monto, 4500);
        key(4'd7);
        idle();
        chk("monto_held", kif.monto, 4500);

        // Nine 9s plus one over the limit
        key(4'hB);
        for (int i = 0; i < 10; i++) key(4'd9);
        key(4'hA);
        idle();
        chk("monto_max", kif.monto, 999999999);

        // Card pulled with a key in flight
        key(4'hB);
        key(4'd1); key(4'd2);
        cur_tj = 1'b0;
        key(4'd3);
        idle(); idle();
        chk("pull_monto", kif.monto, 0);
        chk("pull_digit_count", kif.digit_count, 0);
        cur_am = 1'b0;

        // Asynchronous reset after two PIN digits
        cur_tj = 1'b1;
        idle();
        key(4'd5); key(4'd6);
        idle();
        #1 rst = 1'b0;
        #1;
        chk("arst_add_digit", kif.add_digit, 0);
        chk("arst_digit_count", kif.digit_count, 0);
        chk("arst_monto", kif.monto, 0);
        model_drop();
        sb.delete();
        cur_tj = 1'b0;
        kif.tarjeta_recibida = 1'b0;
        kif.key_valid        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        cur_tj = 1'b1;
        idle();
        key(4'd7); key(4'd8); key(4'd9); key(4'hA);
        key(4'd0); key(4'hA);
        idle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] kc;
            int r;
            cur_tj = ($urandom_range(99) < 97);
            if ($urandom_range(99) < 4) cur_am = ~cur_am;
            r = $urandom_range(99);
            if (r < 60)      kc = 4'($urandom_range(9));
            else if (r < 75) kc = 4'hA;
            else if (r < 85) kc = 4'hB;
            else if (r < 89) kc = 4'hC;
            else             kc = 4'($urandom_range(15, 13));
            step(cur_tj, cur_am, 1'($urandom_range(1)), kc);
        end
        idle(); idle(); idle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
